// File: rtl/rv_pipe_pkg.sv
// Shared definitions for the RV32IM elastic pipeline registers:
// stage FSM encoding and default per-stage field widths.
package rv_pipe_pkg;
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_FULL  = 2'd1;
    localparam logic [1:0] ST_SKID  = 2'd2;

    localparam int EXMEM_CTRL_W = 4;
    localparam int EXMEM_DATA_W = 101;
endpackage

// File: rtl/pipe_skid_entry.sv
// Single parked word (control + data) with its own valid bit; the owning
// stage decides when to load it and when to release or kill it.
module pipe_skid_entry #(
    parameter int CTRL_W = 5,
    parameter int DATA_W = 101
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_load,
    input  logic              i_clear,
    input  logic [CTRL_W-1:0] i_ctrl,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    output logic [CTRL_W-1:0] o_ctrl,
    output logic [DATA_W-1:0] o_data
);
    logic              r_valid;
    logic [CTRL_W-1:0] r_ctrl;
    logic [DATA_W-1:0] r_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
            r_data  <= '0;
        end else if (i_clear) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_ctrl  <= i_ctrl;
            r_data  <= i_data;
        end
    end

    assign o_valid = r_valid;
    assign o_ctrl  = r_ctrl;
    assign o_data  = r_data;
endmodule

// File: rtl/pipe_stage_ctl_reg.sv
// Elastic valid/ready pipeline register with flush; control field is zeroed
// whenever the stage is empty. Define PIPE_STAGE_SKID_EN for a registered in_ready with a skid slot.
module pipe_stage_ctl_reg
    import rv_pipe_pkg::*;
#(
    parameter int                CTRL_W   = 5,
    parameter int                DATA_W   = 101,
    parameter logic [DATA_W-1:0] RST_DATA = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data
);
    logic [1:0]        r_state;
    logic              r_valid;
    logic [CTRL_W-1:0] r_ctrl;
    logic [DATA_W-1:0] r_data;
    logic              w_in_fire;
    logic              w_out_fire;

    assign out_valid  = r_valid;
    assign out_ctrl   = r_ctrl;
    assign out_data   = r_data;
    assign w_out_fire = r_valid & out_ready;

`ifdef PIPE_STAGE_SKID_EN
    logic              r_in_ready;
    logic              w_skid_load;
    logic              w_skid_clear;
    logic              w_skid_valid;
    logic [CTRL_W-1:0] w_skid_ctrl;
    logic [DATA_W-1:0] w_skid_data;

    assign in_ready     = r_in_ready;
    assign w_in_fire    = in_valid & r_in_ready;
    assign w_skid_load  = !flush && (r_state == ST_FULL) && w_in_fire && !out_ready;
    assign w_skid_clear = flush || ((r_state == ST_SKID) && w_out_fire);

    pipe_skid_entry #(
        .CTRL_W (CTRL_W),
        .DATA_W (DATA_W)
    ) u_skid (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_skid_load),
        .i_clear (w_skid_clear),
        .i_ctrl  (in_ctrl),
        .i_data  (in_data),
        .o_valid (w_skid_valid),
        .o_ctrl  (w_skid_ctrl),
        .o_data  (w_skid_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_EMPTY;
            r_valid    <= 1'b0;
            r_ctrl     <= '0;
            r_data     <= RST_DATA;
            r_in_ready <= 1'b1;
        end else if (flush) begin
            // data field deliberately left as-is; only the instruction is killed
            r_state    <= ST_EMPTY;
            r_valid    <= 1'b0;
            r_ctrl     <= '0;
            r_in_ready <= 1'b1;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_in_fire) begin
                        r_state <= ST_FULL;
                        r_valid <= 1'b1;
                        r_ctrl  <= in_ctrl;
                        r_data  <= in_data;
                    end
                end
                ST_FULL: begin
                    if (w_out_fire && w_in_fire) begin
                        r_ctrl <= in_ctrl;
                        r_data <= in_data;
                    end else if (w_out_fire) begin
                        r_state <= ST_EMPTY;
                        r_valid <= 1'b0;
                        r_ctrl  <= '0;
                    end else if (w_in_fire) begin
                        r_state    <= ST_SKID;
                        r_in_ready <= 1'b0;
                    end
                end
                ST_SKID: begin
                    if (w_out_fire && w_skid_valid) begin
                        r_state    <= ST_FULL;
                        r_ctrl     <= w_skid_ctrl;
                        r_data     <= w_skid_data;
                        r_in_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= ST_EMPTY;
                    r_valid    <= 1'b0;
                    r_ctrl     <= '0;
                    r_in_ready <= 1'b1;
                end
            endcase
        end
    end
`else
    assign in_ready  = !r_valid | out_ready;
    assign w_in_fire = in_valid & in_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_EMPTY;
            r_valid <= 1'b0;
            r_ctrl  <= '0;
            r_data  <= RST_DATA;
        end else if (flush) begin
            r_state <= ST_EMPTY;
            r_valid <= 1'b0;
            r_ctrl  <= '0;
        end else if (w_in_fire) begin
            r_state <= ST_FULL;
            r_valid <= 1'b1;
            r_ctrl  <= in_ctrl;
            r_data  <= in_data;
        end else if (w_out_fire) begin
            r_state <= ST_EMPTY;
            r_valid <= 1'b0;
            r_ctrl  <= '0;
        end
    end
`endif
endmodule

// File: tb/tb_pipe_stage_ctl_reg.sv
// Self-checking bench for pipe_stage_ctl_reg: vector table, directed corner
// sequences and a randomized run against a queue-based reference model.
module tb_pipe_stage_ctl_reg;
    localparam int             CW  = 5;
    localparam int             DW  = 16;
    localparam logic [DW-1:0]  RST = 16'hC3A5;
`ifdef PIPE_STAGE_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [CW-1:0] in_ctrl = '0;
    logic [DW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [CW-1:0] out_ctrl;
    logic [DW-1:0] out_data;

    int total = 0;
    int bad   = 0;

    pipe_stage_ctl_reg #(
        .CTRL_W   (CW),
        .DATA_W   (DW),
        .RST_DATA (RST)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          fl;
        logic          iv;
        logic [CW-1:0] ic;
        logic [DW-1:0] id;
        logic          ordy;
        logic          e_ir;
        logic          e_v;
        logic [CW-1:0] e_c;
        logic [DW-1:0] e_d;
    } vec_t;

    vec_t vecs[8];
    logic [CW+DW-1:0] q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [CW-1:0] c, input logic [DW-1:0] d);
        flush = 1'b0; in_valid = 1'b1; in_ctrl = c; in_data = d; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #3;
        reset = 1'b0;
        step();
    endtask

    initial begin
        //          fl  iv  ic     id        or   ir  v   c      d
        vecs[0] = '{0, 1, 5'h03, 16'h0011, 1, 1, 1, 5'h03, 16'h0011};
        vecs[1] = '{0, 1, 5'h05, 16'h0022, 1, 1, 1, 5'h05, 16'h0022};
        vecs[2] = '{0, 0, 5'h00, 16'h0000, 1, 1, 0, 5'h00, 16'h0022};
        vecs[3] = '{0, 0, 5'h00, 16'h0000, 0, 1, 0, 5'h00, 16'h0022};
        vecs[4] = '{0, 1, 5'h07, 16'h0033, 0, 1, 1, 5'h07, 16'h0033};
        vecs[5] = '{1, 0, 5'h00, 16'h0000, 1, 1, 0, 5'h00, 16'h0033};
        vecs[6] = '{0, 1, 5'h1F, 16'h0044, 1, 1, 1, 5'h1F, 16'h0044};
        vecs[7] = '{1, 1, 5'h02, 16'h0055, 1, 1, 0, 5'h00, 16'h0044};

        // reset state
        #12;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_ctrl", 32'(out_ctrl), 32'd0);
        chk("rst_data", 32'(out_data), 32'(RST));
        reset = 1'b0;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        step();

        // vector table
        for (int i = 0; i < 8; i++) begin
            flush = vecs[i].fl; in_valid = vecs[i].iv; in_ctrl = vecs[i].ic;
            in_data = vecs[i].id; out_ready = vecs[i].ordy;
            #1;
            chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].e_ir));
            step();
            chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(vecs[i].e_v));
            chk($sformatf("vec%0d_ctrl", i), 32'(out_ctrl), 32'(vecs[i].e_c));
            chk($sformatf("vec%0d_data", i), 32'(out_data), 32'(vecs[i].e_d));
            $display("vec %0d: v=%0b c=%h d=%h", i, out_valid, out_ctrl, out_data);
        end
        flush = 1'b0; in_valid = 1'b0;

        // asynchronous reset while FULL
        load(5'h1F, 16'h0F0F);
        chk("midrst_pre_valid", 32'(out_valid), 32'd1);
        reset = 1'b1;
        #1;
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_ctrl", 32'(out_ctrl), 32'd0);
        chk("midrst_data", 32'(out_data), 32'(RST));
        #2;
        reset = 1'b0; out_ready = 1'b0;
        #1;
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        step();

        // streaming without bubbles
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_ctrl = 5'(i + 1); in_data = 16'(i);
            step();
            chk($sformatf("stream%0d_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("stream%0d_data", i), 32'(out_data), 32'(i));
            $display("stream %0d: d=%h", i, out_data);
        end
        in_valid = 1'b0;
        step();
        chk("stream_end_valid", 32'(out_valid), 32'd0);

        // stall with a pending upstream word
        load(5'h03, 16'h00AA);
        in_valid = 1'b1; in_ctrl = 5'h04; in_data = 16'h00BB; out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("stall%0d_in_ready", k), 32'(in_ready), (SKID && k == 0) ? 32'd1 : 32'd0);
            step();
            chk($sformatf("stall%0d_valid", k), 32'(out_valid), 32'd1);
            chk($sformatf("stall%0d_data", k), 32'(out_data), 32'h00AA);
            $display("stall %0d: d=%h ir=%0b", k, out_data, in_ready);
        end
        out_ready = 1'b1;
        if (SKID) in_valid = 1'b0;
        step();
        in_valid = 1'b0;
        chk("stall_rel_valid", 32'(out_valid), 32'd1);
        chk("stall_rel_data", 32'(out_data), 32'h00BB);
        chk("stall_rel_ctrl", 32'(out_ctrl), 32'h04);
        step();
        chk("stall_drain_valid", 32'(out_valid), 32'd0);

        // flush beats a simultaneous in_fire
        load(5'h13, 16'h1234);
        flush = 1'b1; in_valid = 1'b1; in_ctrl = 5'h09; in_data = 16'h5678; out_ready = 1'b0;
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_valid", 32'(out_valid), 32'd0);
        chk("flush_ctrl", 32'(out_ctrl), 32'd0);
        chk("flush_data", 32'(out_data), 32'h1234);
        out_ready = 1'b1;
        step();
        chk("flush_dropped_valid", 32'(out_valid), 32'd0);
        chk("flush_dropped_data", 32'(out_data), 32'h1234);

        // drain to empty
        load(5'h0A, 16'h7777);
        in_valid = 1'b0; out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        #1;
        chk("drain_valid", 32'(out_valid), 32'd0);
        chk("drain_ctrl", 32'(out_ctrl), 32'd0);
        chk("drain_in_ready", 32'(in_ready), 32'd1);

        // randomized traffic against an ordered-queue model
        do_reset();
        q.delete();
        for (int n = 0; n < 10000; n++) begin
            flush     = ($urandom_range(0, 49) == 0);
            in_valid  = ($urandom_range(0, 2) != 0);
            in_ctrl   = CW'($urandom);
            in_data   = DW'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            chk("rnd_valid", 32'(out_valid), 32'(q.size() != 0));
            if (out_valid && q.size() != 0)
                chk("rnd_head", 32'({out_ctrl, out_data}), 32'(q[0]));
            if (!out_valid)
                chk("rnd_ctrl_gated", 32'(out_ctrl), 32'd0);
            chk("rnd_in_ready", 32'(in_ready),
                SKID ? 32'(q.size() < 2) : 32'(q.size() == 0 || out_ready));
            if (flush) begin
                q.delete();
            end else begin
                if (out_valid && out_ready && q.size() != 0) void'(q.pop_front());
                if (in_valid && in_ready) q.push_back({in_ctrl, in_data});
            end
            step();
        end
        $display("random: 10000 cycles, queue depth at end %0d", q.size());

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
